uart_tx_packetizer: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 29 ++
 rtl/uart_tx_req_slot.sv | 55 +++++
 rtl/uart_tx_packetizer.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_packetizer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the UART transmit packetizer slice: FSM state
// encoding, frame lengths, default header byte and default watchdog length.
// No ports (package).
package uart_tx_pkg;

  localparam int DATA_W = 8;

  localparam int FRAME_LEN_BASE = 3;  // START, code, value
  localparam int FRAME_LEN_CSUM = 4;  // START, code, value, XOR checksum

  localparam logic [DATA_W-1:0] START_BYTE_DEFAULT = 8'hA5;
  localparam int                TIMEOUT_DEFAULT    = 2048;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

  // XOR of the three payload-bearing bytes of a frame.
  function automatic logic [DATA_W-1:0] frame_xor(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] c);
    frame_xor = a ^ b ^ c;
  endfunction

endpackage

// File: rtl/uart_tx_req_slot.sv
// uart_tx_req_slot
// One-deep holding register for packet requests.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   req_valid         request offered this cycle
//   req_code/value    request payload
//   free              packetizer has copied the slot this cycle
//   ready             slot empty (request may be accepted)
//   full              slot holds a request
//   code/value        held payload
//   overrun           one-cycle pulse, request offered while slot full
module uart_tx_req_slot
  import uart_tx_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_code,
  input  logic [DATA_W-1:0] req_value,
  input  logic              free,
  output logic              ready,
  output logic              full,
  output logic [DATA_W-1:0] code,
  output logic [DATA_W-1:0] value,
  output logic              overrun
);

  logic full_q;
  logic accept;

  assign ready  = !full_q;
  assign full   = full_q;
  assign accept = req_valid && !full_q;

  // A new capture takes priority over a free landing in the same cycle,
  // so a request is never lost when the two coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept)    full_q <= 1'b1;
      else if (free) full_q <= 1'b0;
      overrun <= req_valid && full_q;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      code  <= req_code;
      value <= req_value;
    end
  end

endmodule

// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer
// Frames a request (code, value) as START_BYTE, code, value and feeds the
// serial transmitter one byte at a time over the has_data / done handshake.
// Optional feature macro: UART_TX_PACKETIZER_CHECKSUM_EN appends a fourth
// byte equal to the XOR of the first three.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   request_valid/code/value     request input, request_ready = slot empty
//   tx_has_data, tx_data         one-cycle start pulse and held byte
//   tx_is_transmitting, tx_done  transmitter status
//   busy                         packet in flight
//   packet_done, overrun,
//   timeout_error                one-cycle status pulses
module uart_tx_packetizer
  import uart_tx_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter logic [DATA_W-1:0] START_BYTE     = START_BYTE_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              request_valid,
  input  logic [DATA_W-1:0] request_code,
  input  logic [DATA_W-1:0] request_value,
  output logic              request_ready,
  output logic              tx_has_data,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_is_transmitting,
  input  logic              tx_done,
  output logic              busy,
  output logic              packet_done,
  output logic              overrun,
  output logic              timeout_error
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
`ifdef UART_TX_PACKETIZER_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [1:0]         LAST_IDX   = 2'(FRAME_LEN - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  tx_state_t          state, state_next;
  logic [1:0]         idx, idx_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               tx_done_p1;
  logic               done_edge;
  logic               slot_free, slot_full, load_en, pkt_done_next, tmo_next;
  logic [DATA_W-1:0]  slot_code, slot_value;
  logic [DATA_W-1:0]  work_code, work_value;
  logic [DATA_W-1:0]  cur_byte;
  logic               unused_tx_busy;

  // The transmitter's busy flag is not needed: the done edge plus the
  // GAP cycle already guarantee it is idle before the next pulse.
  assign unused_tx_busy = tx_is_transmitting;

  uart_tx_req_slot u_slot (
    .clock     (clock),
    .reset     (reset),
    .req_valid (request_valid),
    .req_code  (request_code),
    .req_value (request_value),
    .free      (slot_free),
    .ready     (request_ready),
    .full      (slot_full),
    .code      (slot_code),
    .value     (slot_value),
    .overrun   (overrun)
  );

  // done may be held high for two cycles; only its rising edge counts.
  assign done_edge = tx_done && !tx_done_p1;
  assign busy      = (state != IDLE);

  always_comb begin
    cur_byte = START_BYTE;
    case (idx)
      2'd1:    cur_byte = work_code;
      2'd2:    cur_byte = work_value;
`ifdef UART_TX_PACKETIZER_CHECKSUM_EN
      2'd3:    cur_byte = frame_xor(START_BYTE, work_code, work_value);
`endif
      default: cur_byte = START_BYTE;
    endcase
  end

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    timer_next    = timer;
    slot_free     = 1'b0;
    load_en       = 1'b0;
    pkt_done_next = 1'b0;
    tmo_next      = 1'b0;
    case (state)
      IDLE: begin
        if (slot_full) begin
          slot_free  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        load_en    = 1'b1;
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        timer_next = timer + TIMER_W'(1);
        // A done edge landing on the last watchdog cycle still completes.
        if (done_edge) begin
          state_next = GAP;
        end else if (timer == TIMER_LAST) begin
          tmo_next   = 1'b1;
          idx_next   = 2'd0;
          state_next = IDLE;
        end
      end
      GAP: begin
        if (idx == LAST_IDX) begin
          pkt_done_next = 1'b1;
          idx_next      = 2'd0;
          state_next    = IDLE;
        end else begin
          idx_next   = idx + 2'd1;
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= 2'd0;
      timer         <= '0;
      tx_done_p1    <= 1'b0;
      tx_has_data   <= 1'b0;
      tx_data       <= '0;
      packet_done   <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      timer         <= timer_next;
      tx_done_p1    <= tx_done;
      tx_has_data   <= load_en;
      packet_done   <= pkt_done_next;
      timeout_error <= tmo_next;
      if (load_en) tx_data <= cur_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (slot_free) begin
      work_code  <= slot_code;
      work_value <= slot_value;
    end
  end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
module tb_uart_tx_packetizer;
  import uart_tx_pkg::*;

`ifdef UART_TX_PACKETIZER_CHECKSUM_EN
  localparam int FL = 4;
`else
  localparam int FL = 3;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       request_valid = 1'b0;
  logic [7:0] request_code = 8'h00;
  logic [7:0] request_value = 8'h00;
  logic       request_ready;
  logic       tx_has_data;
  logic [7:0] tx_data;
  logic       tx_is_transmitting = 1'b0;
  logic       tx_done = 1'b0;
  logic       busy, packet_done, overrun, timeout_error;

  uart_tx_packetizer #(.TIMEOUT_CYCLES(64), .START_BYTE(8'hA5)) dut (
    .clock              (clock),
    .reset              (reset),
    .request_valid      (request_valid),
    .request_code       (request_code),
    .request_value      (request_value),
    .request_ready      (request_ready),
    .tx_has_data        (tx_has_data),
    .tx_data            (tx_data),
    .tx_is_transmitting (tx_is_transmitting),
    .tx_done            (tx_done),
    .busy               (busy),
    .packet_done        (packet_done),
    .overrun            (overrun),
    .timeout_error      (timeout_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor (sampled on the falling edge)
  logic [7:0] bytes_q[$];
  int hd_cyc_q[$];
  int pd_cyc_q[$];
  int pd_cnt = 0, ov_cnt = 0, to_cnt = 0, to_cyc = 0;

  always @(negedge clock) begin
    if (tx_has_data) begin
      bytes_q.push_back(tx_data);
      hd_cyc_q.push_back(cyc);
    end
    if (packet_done) begin
      pd_cnt++;
      pd_cyc_q.push_back(cyc);
    end
    if (overrun) ov_cnt++;
    if (timeout_error) begin
      to_cnt++;
      to_cyc = cyc;
    end
  end

  // Transmitter responder
  bit resp_en = 1'b1;
  int done_len = 1;
  int wait_cnt = -1;
  int hold_cnt = 0;
  int rise_cyc = 0;

  always @(negedge clock) begin
    if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) begin
        tx_done = 1'b0;
        tx_is_transmitting = 1'b0;
      end
    end
    if (wait_cnt > 0) wait_cnt--;
    else if (wait_cnt == 0) begin
      tx_done  = 1'b1;
      hold_cnt = done_len;
      rise_cyc = cyc;
      wait_cnt = -1;
    end
    if (tx_has_data && resp_en) begin
      wait_cnt = 12;
      tx_is_transmitting = 1'b1;
    end
  end

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] v);
    request_valid = 1'b1;
    request_code  = c;
    request_value = v;
    step(1);
    request_valid = 1'b0;
  endtask

  task automatic wait_pd(input int target, input int budget, input string tag);
    int n = 0;
    while (pd_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(pd_cnt >= target), 32'd1);
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] c, input logic [7:0] v);
    case (i)
      0:       exp_byte = 8'hA5;
      1:       exp_byte = c;
      2:       exp_byte = v;
      default: exp_byte = 8'hA5 ^ c ^ v;
    endcase
  endfunction

  task automatic check_frame(input int base, input logic [7:0] c, input logic [7:0] v, input string tag);
    for (int i = 0; i < FL; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(bytes_q[base + i]), 32'(exp_byte(i, c, v)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, pd0, d, n;

    // Reset state
    step(3);
    check("rst_ready", 32'(request_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_has_data", 32'(tx_has_data), 32'd0);
    check("rst_pulses", 32'({packet_done, overrun, timeout_error}), 32'd0);
    reset = 1'b0;
    step(2);

    // Single request 01/2C
    send(8'h01, 8'h2C);
    check("t1_ready_low", 32'(request_ready), 32'd0);
    wait_pd(1, 400, "t1_done_seen");
    d = pd_cyc_q[0] - rise_cyc;
    check("t1_pd_latency", 32'(d >= 1 && d <= 2), 32'd1);
    step(5);
    check("t1_pulse_count", 32'(bytes_q.size()), 32'(FL));
    check("t1_pd_count", 32'(pd_cnt), 32'd1);
    check_frame(0, 8'h01, 8'h2C, "t1");
    check("t1_idle", 32'(busy), 32'd0);

    // tx_done held two cycles per byte
    done_len = 2;
    base = bytes_q.size();
    send(8'h5A, 8'hC3);
    wait_pd(2, 400, "t2_done_seen");
    step(5);
    check("t2_pulse_count", 32'(bytes_q.size() - base), 32'(FL));
    check("t2_pd_count", 32'(pd_cnt), 32'd2);
    check_frame(base, 8'h5A, 8'hC3, "t2");
    done_len = 1;

    // Requests at cycle 0 and 5
    base = bytes_q.size();
    send(8'h11, 8'h22);
    step(4);
    check("t3_ready_mid", 32'(request_ready), 32'd1);
    send(8'h33, 8'h44);
    wait_pd(4, 800, "t3_done_seen");
    step(5);
    check("t3_pulse_count", 32'(bytes_q.size() - base), 32'(2 * FL));
    check("t3_overrun", 32'(ov_cnt), 32'd0);
    check_frame(base, 8'h11, 8'h22, "t3a");
    check_frame(base + FL, 8'h33, 8'h44, "t3b");
    check("t3_b2b_gap", 32'(hd_cyc_q[base + FL] - pd_cyc_q[2]), 32'd2);

    // Three requests during one packet
    base = bytes_q.size();
    send(8'h55, 8'h66);
    step(3);
    send(8'h77, 8'h88);
    check("t4_ready_full", 32'(request_ready), 32'd0);
    send(8'h99, 8'hAA);
    step(2);
    check("t4_overrun_one", 32'(ov_cnt), 32'd1);
    wait_pd(6, 800, "t4_done_seen");
    step(60);
    check("t4_pulse_count", 32'(bytes_q.size() - base), 32'(2 * FL));
    check("t4_pd_count", 32'(pd_cnt), 32'd6);
    check_frame(base, 8'h55, 8'h66, "t4a");
    check_frame(base + FL, 8'h77, 8'h88, "t4b");
    check("t4_overrun_final", 32'(ov_cnt), 32'd1);

    // Watchdog timeout with no tx_done
    resp_en = 1'b0;
    base = bytes_q.size();
    send(8'hDE, 8'hAD);
    n = 0;
    while (to_cnt < 1 && n < 300) begin
      step(1);
      n++;
    end
    check("t5_timeout_seen", 32'(to_cnt), 32'd1);
    check("t5_timeout_lat", 32'(to_cyc - hd_cyc_q[base]), 32'd64);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_one_pulse", 32'(bytes_q.size() - base), 32'd1);
    check("t5_no_pd", 32'(pd_cnt), 32'd6);
    resp_en = 1'b1;
    step(3);
    base = bytes_q.size();
    send(8'h0F, 8'hF0);
    wait_pd(7, 400, "t5_next_done");
    step(5);
    check("t5_next_count", 32'(bytes_q.size() - base), 32'(FL));
    check_frame(base, 8'h0F, 8'hF0, "t5n");

`ifdef UART_TX_PACKETIZER_CHECKSUM_EN
    // Checksum frame
    base = bytes_q.size();
    send(8'h03, 8'h10);
    wait_pd(8, 400, "t6_done_seen");
    step(5);
    check("t6_csum", 32'(bytes_q[base + 3]), 32'hB6);
    check("t6_count", 32'(bytes_q.size() - base), 32'd4);
`endif

    // Reset during byte 2 with the slot full
    pd0 = pd_cnt;
    base = bytes_q.size();
    send(8'hC0, 8'hDE);
    n = 0;
    while (bytes_q.size() < base + 2 && n < 200) begin
      step(1);
      n++;
    end
    check("t7_byte2_reached", 32'(bytes_q.size() - base), 32'd2);
    send(8'hEE, 8'hFF);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t7_busy_cleared", 32'(busy), 32'd0);
    check("t7_slot_cleared", 32'(request_ready), 32'd1);
    step(80);
    check("t7_no_pd", 32'(pd_cnt), 32'(pd0));
    check("t7_no_more_bytes", 32'(bytes_q.size() - base), 32'd2);
    base = bytes_q.size();
    send(8'h12, 8'h34);
    wait_pd(pd0 + 1, 400, "t7_next_done");
    step(5);
    check_frame(base, 8'h12, 8'h34, "t7n");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
